// File: rtl/exec_pkg.sv
// Shared execution-side definitions for the dispatch scheduler.
// Holds the packet width, instruction header field positions, the op class
// encoding, the decoded header struct and small decode/routing helpers.
package exec_pkg;

  localparam int unsigned DW = 128;

  // Header field positions inside an instruction packet
  localparam int unsigned RdLsb     = 0;
  localparam int unsigned Rs1Lsb    = 5;
  localparam int unsigned Rs2Lsb    = 10;
  localparam int unsigned ClsLsb    = 15;
  localparam int unsigned RdWeBit   = 17;
  localparam int unsigned UseRs1Bit = 18;
  localparam int unsigned UseRs2Bit = 19;
  localparam int unsigned HdrW      = 20;

  // Execution unit indices (bit positions in unit vectors)
  localparam int unsigned UnitAlu0 = 0;
  localparam int unsigned UnitAlu1 = 1;
  localparam int unsigned UnitMem  = 2;
  localparam int unsigned NUnits   = 3;

  typedef enum logic [1:0] {
    ClsAlu = 2'd0,
    ClsMul = 2'd1,
    ClsMem = 2'd2,
    ClsBr  = 2'd3
  } op_class_e;

  typedef struct packed {
    logic      use_rs2;
    logic      use_rs1;
    logic      rd_we;
    op_class_e cls;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [4:0] rd;
  } hdr_t;

  function automatic hdr_t decode_hdr(logic [HdrW-1:0] h);
    hdr_t d;
    d.rd      = h[RdLsb +: 5];
    d.rs1     = h[Rs1Lsb +: 5];
    d.rs2     = h[Rs2Lsb +: 5];
    d.cls     = op_class_e'(h[ClsLsb +: 2]);
    d.rd_we   = h[RdWeBit];
    d.use_rs1 = h[UseRs1Bit];
    d.use_rs2 = h[UseRs2Bit];
    return d;
  endfunction

  // One-hot unit choice for a class given the free units; zero when none fits.
  // ALU/BR prefer alu0 and fall back to alu1.
  function automatic logic [NUnits-1:0] route_unit(op_class_e cls, logic [NUnits-1:0] free);
    logic [NUnits-1:0] r;
    r = '0;
    unique case (cls)
      ClsAlu, ClsBr: begin
        if (free[UnitAlu0])      r[UnitAlu0] = 1'b1;
        else if (free[UnitAlu1]) r[UnitAlu1] = 1'b1;
      end
      ClsMul:  r[UnitAlu1] = free[UnitAlu1];
      ClsMem:  r[UnitMem]  = free[UnitMem];
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register busy scoreboard.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush_i     - clear every busy bit at the next edge
//   set_i       - registers becoming busy this cycle (set wins over clear)
//   clr_i       - registers released by writeback this cycle
//   busy_o      - registered busy vector; bit 0 (x0) is never busy
module reg_scoreboard #(
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic [NREG-1:0] set_i,
  input  logic [NREG-1:0] clr_i,
  output logic [NREG-1:0] busy_o
);

  logic [NREG-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = (busy_q & ~clr_i) | set_i;
    if (flush_i) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/dispatch_scheduler.sv
// Dual-issue in-order dispatch scheduler.
// Looks at the two oldest buffer entries (s0, s1), checks source operands
// against a register scoreboard and unit availability, and loads issued
// packets into per-unit output registers (alu0, alu1, mem) one cycle later.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   flush                      - drop held packets and scoreboard, block issue
//   s0_*/s1_*                  - oldest / next-oldest buffer entries
//   pop, stall                 - entries consumed this cycle (combinational)
//   alu0_*/alu1_*/mem_*        - unit output registers with valid/ready
//   wb0_*/wb1_*                - writeback releases of busy registers
module dispatch_scheduler #(
  parameter int unsigned DW   = exec_pkg::DW,
  parameter int unsigned NREG = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          s0_valid,
  input  logic [DW-1:0] s0_data,
  input  logic          s1_valid,
  input  logic [DW-1:0] s1_data,
  output logic [1:0]    pop,
  output logic          stall,
  output logic          alu0_valid,
  output logic [DW-1:0] alu0_data,
  input  logic          alu0_ready,
  output logic          alu1_valid,
  output logic [DW-1:0] alu1_data,
  input  logic          alu1_ready,
  output logic          mem_valid,
  output logic [DW-1:0] mem_data,
  input  logic          mem_ready,
  input  logic          wb0_valid,
  input  logic [4:0]    wb0_rd,
  input  logic          wb1_valid,
  input  logic [4:0]    wb1_rd
);
  import exec_pkg::*;

  hdr_t h0, h1;
  assign h0 = decode_hdr(s0_data[HdrW-1:0]);
  assign h1 = decode_hdr(s1_data[HdrW-1:0]);

  logic [NREG-1:0]   busy, set_vec, clr_vec;
  logic [31:0]       busy32;
  logic [NUnits-1:0] unit_ready, unit_free, free_after0, route0, route1;
  logic [NUnits-1:0] unit_valid_q, unit_valid_d;
  logic [DW-1:0]     unit_data_q [NUnits];
  logic [DW-1:0]     unit_data_d [NUnits];
  logic              src_ok0, src_ok1, hazard1, issue0, issue1;

  function automatic logic src_ok(hdr_t h, logic [31:0] b);
    return !(h.use_rs1 && b[h.rs1]) && !(h.use_rs2 && b[h.rs2]);
  endfunction

  // Widen the busy vector so any 5-bit source index is a legal lookup.
  always_comb begin
    busy32 = '0;
    for (int i = 0; i < NREG; i++) busy32[i] = busy[i];
  end

  always_comb begin
    unit_ready  = {mem_ready, alu1_ready, alu0_ready};
    unit_free   = ~unit_valid_q | unit_ready;
    src_ok0     = src_ok(h0, busy32);
    src_ok1     = src_ok(h1, busy32);
    route0      = route_unit(h0.cls, unit_free);
    issue0      = rst_n && !flush && s0_valid && src_ok0 && (route0 != '0);
    free_after0 = unit_free & ~route0;
    route1      = route_unit(h1.cls, free_after0);
    // Slot1 may not depend on or overwrite slot0's destination.
    hazard1     = h0.rd_we && ((h1.use_rs1 && (h1.rs1 == h0.rd)) ||
                               (h1.use_rs2 && (h1.rs2 == h0.rd)) ||
                               (h1.rd_we   && (h1.rd  == h0.rd)));
    issue1      = issue0 && (h0.cls != ClsBr) && s1_valid && src_ok1 && !hazard1 &&
                  (route1 != '0);
    pop         = issue0 ? (issue1 ? 2'd2 : 2'd1) : 2'd0;
    stall       = rst_n && s0_valid && (pop == 2'd0);
  end

  always_comb begin
    for (int u = 0; u < NUnits; u++) begin
      unit_valid_d[u] = unit_valid_q[u] && !unit_ready[u];
      unit_data_d[u]  = unit_data_q[u];
      if (issue0 && route0[u]) begin
        unit_valid_d[u] = 1'b1;
        unit_data_d[u]  = s0_data;
      end else if (issue1 && route1[u]) begin
        unit_valid_d[u] = 1'b1;
        unit_data_d[u]  = s1_data;
      end
      if (flush) unit_valid_d[u] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_valid_q <= '0;
      for (int u = 0; u < NUnits; u++) unit_data_q[u] <= '0;
    end else begin
      unit_valid_q <= unit_valid_d;
      for (int u = 0; u < NUnits; u++) unit_data_q[u] <= unit_data_d[u];
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      set_vec[i] = (issue0 && h0.rd_we && (h0.rd == 5'(i))) ||
                   (issue1 && h1.rd_we && (h1.rd == 5'(i)));
      clr_vec[i] = (wb0_valid && (wb0_rd == 5'(i))) ||
                   (wb1_valid && (wb1_rd == 5'(i)));
    end
  end

  reg_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(flush),
    .set_i  (set_vec),
    .clr_i  (clr_vec),
    .busy_o (busy)
  );

  assign alu0_valid = unit_valid_q[UnitAlu0];
  assign alu1_valid = unit_valid_q[UnitAlu1];
  assign mem_valid  = unit_valid_q[UnitMem];
  assign alu0_data  = unit_data_q[UnitAlu0];
  assign alu1_data  = unit_data_q[UnitAlu1];
  assign mem_data   = unit_data_q[UnitMem];

endmodule

// File: tb/tb_dispatch_scheduler.sv
// Self-checking bench for dispatch_scheduler: directed scenarios followed by
// random traffic, all checked against a behavioural model of issue rules.
module tb_dispatch_scheduler;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n, flush;
  logic          s0_valid, s1_valid;
  logic [DW-1:0] s0_data, s1_data;
  logic [1:0]    pop;
  logic          stall;
  logic          alu0_valid, alu1_valid, mem_valid;
  logic [DW-1:0] alu0_data, alu1_data, mem_data;
  logic          alu0_ready, alu1_ready, mem_ready;
  logic          wb0_valid, wb1_valid;
  logic [4:0]    wb0_rd, wb1_rd;

  dispatch_scheduler #(.DW(DW), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s0_valid(s0_valid), .s0_data(s0_data), .s1_valid(s1_valid), .s1_data(s1_data),
    .pop(pop), .stall(stall),
    .alu0_valid(alu0_valid), .alu0_data(alu0_data), .alu0_ready(alu0_ready),
    .alu1_valid(alu1_valid), .alu1_data(alu1_data), .alu1_ready(alu1_ready),
    .mem_valid(mem_valid), .mem_data(mem_data), .mem_ready(mem_ready),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb1_valid(wb1_valid), .wb1_rd(wb1_rd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: unit 0=alu0, 1=alu1, 2=mem
  bit            m_v [3];
  logic [DW-1:0] m_d [3];
  bit   [31:0]   m_busy;
  int            e_u0, e_u1, e_pop;
  bit            e_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int fld(logic [DW-1:0] p, int lo, int w);
    return int'((p >> lo) & ((128'd1 << w) - 128'd1));
  endfunction

  function automatic bit srcs_free(logic [DW-1:0] p);
    return (fld(p, 18, 1) == 0 || !m_busy[fld(p, 5, 5)]) &&
           (fld(p, 19, 1) == 0 || !m_busy[fld(p, 10, 5)]);
  endfunction

  // Class 1 (MUL) -> alu1, class 2 (MEM) -> mem, ALU/BR -> alu0 then alu1.
  function automatic int pick(int cls, bit f0, bit f1, bit f2);
    if (cls == 1) return f1 ? 1 : -1;
    if (cls == 2) return f2 ? 2 : -1;
    return f0 ? 0 : (f1 ? 1 : -1);
  endfunction

  task automatic model_eval();
    bit free [3];
    bit raw, waw;
    e_u0 = -1;
    e_u1 = -1;
    if (!flush) begin
      free[0] = !m_v[0] || alu0_ready;
      free[1] = !m_v[1] || alu1_ready;
      free[2] = !m_v[2] || mem_ready;
      if (s0_valid && srcs_free(s0_data))
        e_u0 = pick(fld(s0_data, 15, 2), free[0], free[1], free[2]);
      if (e_u0 >= 0) begin
        free[e_u0] = 0;
        raw = fld(s0_data, 17, 1) == 1 &&
              ((fld(s1_data, 18, 1) == 1 && fld(s1_data, 5, 5) == fld(s0_data, 0, 5)) ||
               (fld(s1_data, 19, 1) == 1 && fld(s1_data, 10, 5) == fld(s0_data, 0, 5)));
        waw = fld(s0_data, 17, 1) == 1 && fld(s1_data, 17, 1) == 1 &&
              fld(s1_data, 0, 5) == fld(s0_data, 0, 5);
        if (s1_valid && fld(s0_data, 15, 2) != 3 && srcs_free(s1_data) && !raw && !waw)
          e_u1 = pick(fld(s1_data, 15, 2), free[0], free[1], free[2]);
      end
    end
    e_pop   = (e_u0 < 0) ? 0 : ((e_u1 < 0) ? 1 : 2);
    e_stall = s0_valid && e_pop == 0;
  endtask

  task automatic model_update();
    if (flush) begin
      for (int u = 0; u < 3; u++) m_v[u] = 0;
      m_busy = '0;
      return;
    end
    if (alu0_ready) m_v[0] = 0;
    if (alu1_ready) m_v[1] = 0;
    if (mem_ready)  m_v[2] = 0;
    if (e_u0 >= 0) begin m_v[e_u0] = 1; m_d[e_u0] = s0_data; end
    if (e_u1 >= 0) begin m_v[e_u1] = 1; m_d[e_u1] = s1_data; end
    if (wb0_valid) m_busy[wb0_rd] = 0;
    if (wb1_valid) m_busy[wb1_rd] = 0;
    if (e_u0 >= 0 && fld(s0_data, 17, 1) == 1) m_busy[fld(s0_data, 0, 5)] = 1;
    if (e_u1 >= 0 && fld(s1_data, 17, 1) == 1) m_busy[fld(s1_data, 0, 5)] = 1;
    m_busy[0] = 0;
  endtask

  // Called with clk low and inputs set; checks pop/stall, clocks, checks units.
  task automatic step(input string tag);
    logic          ov [3];
    logic [DW-1:0] od [3];
    #1;
    model_eval();
    chk({tag, ":pop"}, 32'(pop), e_pop);
    chk({tag, ":stall"}, 32'(stall), 32'(e_stall));
    @(posedge clk);
    model_update();
    #1;
    ov = '{alu0_valid, alu1_valid, mem_valid};
    od = '{alu0_data, alu1_data, mem_data};
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("%s:v%0d", tag, u), 32'(ov[u]), 32'(m_v[u]));
      if (m_v[u]) chkd($sformatf("%s:d%0d", tag, u), od[u], m_d[u]);
    end
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] mk(int cls, int rd, int rs1, int rs2, bit we, bit u1,
                                       bit u2);
    logic [DW-1:0] p;
    p = {$urandom(), $urandom(), $urandom(), $urandom()};
    p[4:0]   = rd[4:0];
    p[9:5]   = rs1[4:0];
    p[14:10] = rs2[4:0];
    p[16:15] = cls[1:0];
    p[17]    = we;
    p[18]    = u1;
    p[19]    = u2;
    return p;
  endfunction

  task automatic drive(input bit v0, input logic [DW-1:0] p0, input bit v1,
                       input logic [DW-1:0] p1);
    s0_valid = v0;
    s0_data  = p0;
    s1_valid = v1;
    s1_data  = p1;
  endtask

  logic [DW-1:0] pa, pb, pc;

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    alu0_ready = 1'b1; alu1_ready = 1'b1; mem_ready = 1'b1;
    wb0_valid = 1'b0; wb1_valid = 1'b0; wb0_rd = '0; wb1_rd = '0;
    drive(1, mk(0, 1, 0, 0, 1, 0, 0), 1, mk(2, 2, 0, 0, 1, 0, 0));
    for (int u = 0; u < 3; u++) begin m_v[u] = 0; m_d[u] = '0; end
    m_busy = '0;

    // Reset: outputs quiet even with s0 presented
    #2;
    chk("rst_pop", 32'(pop), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_v", {29'd0, mem_valid, alu1_valid, alu0_valid}, 0);
    chkd("rst_d0", alu0_data, '0);
    chkd("rst_d1", alu1_data, '0);
    chkd("rst_d2", mem_data, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, '0, 0, '0);

    // ALU + MEM dual issue
    pa = mk(0, 1, 2, 3, 1, 1, 1);
    pb = mk(2, 4, 6, 0, 1, 1, 0);
    drive(1, pa, 1, pb);
    #1 chk("dual_pop", 32'(pop), 2);
    step("dual");
    chk("dual_alu0_v", 32'(alu0_valid), 1);
    chk("dual_mem_v", 32'(mem_valid), 1);
    chkd("dual_alu0_d", alu0_data, pa);
    chkd("dual_mem_d", mem_data, pb);
    drive(0, '0, 0, '0);
    wb0_valid = 1; wb0_rd = 5'd1; wb1_valid = 1; wb1_rd = 5'd4;
    step("drain0");
    wb0_valid = 0; wb1_valid = 0;

    // RAW between slots, then scoreboard wait for wb of r5
    pa = mk(0, 5, 0, 0, 1, 0, 0);
    pb = mk(0, 6, 5, 0, 1, 1, 0);
    drive(1, pa, 1, pb);
    #1 chk("raw_pop", 32'(pop), 1);
    step("raw");
    drive(1, pb, 0, '0);
    #1 chk("raw_busy_pop", 32'(pop), 0);
    step("raw_busy");
    wb0_valid = 1; wb0_rd = 5'd5;
    #1 chk("raw_wb_pop", 32'(pop), 0);
    step("raw_wb");
    wb0_valid = 0;
    #1 chk("raw_go_pop", 32'(pop), 1);
    step("raw_go");

    // Two MULs compete for alu1
    pa = mk(1, 7, 0, 0, 1, 0, 0);
    pb = mk(1, 8, 0, 0, 1, 0, 0);
    drive(1, pa, 1, pb);
    #1 chk("mul_pop", 32'(pop), 1);
    step("mul");
    drive(1, pb, 0, '0);
    #1 chk("mul2_pop", 32'(pop), 1);
    step("mul2");
    chkd("mul2_d", alu1_data, pb);
    drive(0, '0, 0, '0);
    step("drain1");

    // alu0 held -> ALU/BR falls back to alu1; both held -> stall
    pa = mk(0, 0, 0, 0, 0, 0, 0);
    drive(1, pa, 0, '0);
    step("fill0");
    alu0_ready = 0;
    pb = mk(3, 0, 0, 0, 0, 0, 0);
    drive(1, pb, 0, '0);
    #1 chk("alt_pop", 32'(pop), 1);
    step("alt");
    chk("alt_alu1_v", 32'(alu1_valid), 1);
    chkd("alt_alu1_d", alu1_data, pb);
    chkd("alt_alu0_d", alu0_data, pa);
    alu1_ready = 0;
    pc = mk(0, 0, 0, 0, 0, 0, 0);
    drive(1, pc, 0, '0);
    #1 chk("full_stall", 32'(stall), 1);
    chk("full_pop", 32'(pop), 0);
    step("full");

    // Flush with all three units held and r3 busy
    mem_ready = 0;
    pa = mk(2, 3, 0, 0, 1, 0, 0);
    drive(1, pa, 0, '0);
    #1 chk("mem3_pop", 32'(pop), 1);
    step("mem3");
    chk("mem3_v", {29'd0, mem_valid, alu1_valid, alu0_valid}, 7);
    flush = 1;
    alu0_ready = 1; alu1_ready = 1; mem_ready = 1;
    pb = mk(0, 9, 3, 0, 1, 1, 0);
    drive(1, pb, 0, '0);
    #1 chk("flush_pop", 32'(pop), 0);
    step("flush");
    chk("flush_v", {29'd0, mem_valid, alu1_valid, alu0_valid}, 0);
    flush = 0;
    #1 chk("flush_sb_pop", 32'(pop), 1);
    step("flush_sb");

    // Writes to x0 never mark it busy
    pa = mk(0, 0, 0, 0, 1, 0, 0);
    drive(1, pa, 0, '0);
    #1 chk("x0_pop", 32'(pop), 1);
    step("x0");
    pb = mk(0, 10, 0, 0, 1, 1, 0);
    drive(1, pb, 0, '0);
    #1 chk("x0_use_pop", 32'(pop), 1);
    step("x0_use");

    // Random traffic with a narrow register range to provoke hazards
    for (int n = 0; n < 400; n++) begin
      flush      = ($urandom_range(0, 29) == 0);
      alu0_ready = ($urandom_range(0, 3) != 0);
      alu1_ready = ($urandom_range(0, 3) != 0);
      mem_ready  = ($urandom_range(0, 3) != 0);
      wb0_valid  = ($urandom_range(0, 2) == 0);
      wb1_valid  = ($urandom_range(0, 2) == 0);
      wb0_rd     = 5'($urandom_range(0, 7));
      wb1_rd     = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 4) != 0,
            mk($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1),
            $urandom_range(0, 3) != 0,
            mk($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1));
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
